// File: rtl/lz77_search_pkg.sv
// Shared types and helpers for the windowed LZ77 pattern search.
package lz77_search_pkg;

  typedef enum logic [1:0] {IDLE, SEARCH, RESULT} state_t;

  // Upper bound on PATTERN_MAX supported by lead_ones.
  localparam int MAX_PATTERN = 32;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int len_w(input int pmax);
    return $clog2(pmax + 1);
  endfunction

  // Number of leading equal symbols, capped at lim.
  function automatic int unsigned lead_ones(input logic [MAX_PATTERN-1:0] eq,
                                            input int unsigned lim);
    int unsigned n;
    n = 0;
    for (int k = 0; k < MAX_PATTERN; k++)
      if (n == k && k < lim && eq[k]) n = k + 1;
    return n;
  endfunction

endpackage

// File: rtl/lz77_match_length_unit.sv
// Match length of the pattern against one candidate window slice, bounded by
// the pattern length and by how many valid symbols follow the candidate.
module lz77_match_length_unit import lz77_search_pkg::*; #(
  parameter int DATA_WIDTH  = 8,
  parameter int PATTERN_MAX = 7,
  parameter int LEN_W       = 3
)(
  input  logic [DATA_WIDTH-1:0] slice   [PATTERN_MAX],
  input  logic [DATA_WIDTH-1:0] pattern [PATTERN_MAX],
  input  logic [LEN_W-1:0]      length,
  input  logic [LEN_W-1:0]      limit,
  output logic [LEN_W-1:0]      match_len
);

  logic [MAX_PATTERN-1:0] eq;
  logic [LEN_W-1:0]       lim;

  always_comb begin
    eq = '0;
    for (int k = 0; k < PATTERN_MAX; k++) eq[k] = (slice[k] == pattern[k]);
    lim       = (length < limit) ? length : limit;
    match_len = LEN_W'(lead_ones(eq, 32'(lim)));
  end

endmodule

// File: rtl/lz77_windowed_pattern_search.sv
// Circular history window with a multi-cycle longest-prefix search,
// POSITIONS_PER_CYCLE candidates per cycle, ties resolved to the lowest index.
module lz77_windowed_pattern_search import lz77_search_pkg::*; #(
  parameter  int DATA_WIDTH          = 8,
  parameter  int HISTORY_DEPTH       = 4096,
  parameter  int PATTERN_MAX         = 7,
  parameter  int POSITIONS_PER_CYCLE = 64,
  localparam int IDX_W               = idx_w(HISTORY_DEPTH),
  localparam int LEN_W               = len_w(PATTERN_MAX)
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  historyClear,
  output logic                  writeDataReady,
  input  logic                  writeDataValid,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic                  patternDataReady,
  input  logic                  patternDataValid,
  input  logic [DATA_WIDTH-1:0] patternData [PATTERN_MAX],
  input  logic [LEN_W-1:0]      patternDataLength,
  input  logic                  matchResultReady,
  output logic                  matchResultValid,
  output logic [IDX_W-1:0]      matchResultIndex,
  output logic [LEN_W-1:0]      matchResultLength
);

  localparam int PPC         = POSITIONS_PER_CYCLE;
  localparam int SCAN_CYCLES = HISTORY_DEPTH / PPC;
  localparam int CYC_W       = idx_w(SCAN_CYCLES);
  localparam int POS_W       = idx_w(PPC);
  localparam int LVLS        = $clog2(PPC);
  localparam int SEG_N       = PPC + PATTERN_MAX - 1;
  localparam int FILL_W      = IDX_W + 1;

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] win [HISTORY_DEPTH];
  logic [IDX_W-1:0]      wr_ptr;
  logic [FILL_W-1:0]     fill;
  logic [DATA_WIDTH-1:0] pat [PATTERN_MAX];
  logic [LEN_W-1:0]      pat_len;
  logic [CYC_W-1:0]      cyc;
  logic                  scan_done;
  logic [LEN_W-1:0]      acc_len;
  logic [IDX_W-1:0]      acc_idx;

  logic                  pat_fire, wr_fire;
  logic [IDX_W-1:0]      base, oldest;
  logic [DATA_WIDTH-1:0] seg [SEG_N];
  logic [LEN_W-1:0]      cand_len [PPC];
  logic [LEN_W-1:0]      t_len [LVLS+1][PPC];
  logic [POS_W-1:0]      t_pos [LVLS+1][PPC];
  logic [LEN_W-1:0]      cyc_best_len;
  logic [IDX_W-1:0]      cyc_best_idx;

  assign pat_fire = patternDataValid && patternDataReady;
  assign wr_fire  = writeDataValid && writeDataReady && !historyClear;
  assign base     = IDX_W'(cyc) << LVLS;
  assign oldest   = wr_ptr - fill[IDX_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    writeDataReady   = 1'b0;
    patternDataReady = 1'b0;
    matchResultValid = 1'b0;
    unique case (state)
      IDLE: begin
        writeDataReady   = 1'b1;
        patternDataReady = 1'b1;
        if (patternDataValid)
          state_next = (patternDataLength == '0) ? RESULT : SEARCH;
      end
      SEARCH: if (scan_done) state_next = RESULT;
      RESULT: begin
        matchResultValid = 1'b1;
        if (matchResultReady) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Segment read wraps so the last candidates of a cycle see the window start.
  always_comb begin
    for (int j = 0; j < SEG_N; j++) seg[j] = win[base + IDX_W'(j)];
  end

  for (genvar p = 0; p < PPC; p++) begin : g_pos
    logic [DATA_WIDTH-1:0] slice [PATTERN_MAX];
    logic [IDX_W-1:0]      off;
    logic [FILL_W-1:0]     avail;
    logic [LEN_W-1:0]      limit;
    always_comb begin
      for (int k = 0; k < PATTERN_MAX; k++) slice[k] = seg[p + k];
      off   = base + IDX_W'(p) - oldest;
      // Symbols remaining up to the newest one; zero outside the filled region.
      avail = ({1'b0, off} < fill) ? fill - {1'b0, off} : '0;
      limit = (avail > FILL_W'(PATTERN_MAX)) ? LEN_W'(PATTERN_MAX) : LEN_W'(avail);
    end
    lz77_match_length_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .PATTERN_MAX(PATTERN_MAX),
      .LEN_W      (LEN_W)
    ) u_mlu (
      .slice    (slice),
      .pattern  (pat),
      .length   (pat_len),
      .limit    (limit),
      .match_len(cand_len[p])
    );
  end

  // Pairwise tree; the right leg wins only when strictly longer.
  always_comb begin
    for (int l = 0; l <= LVLS; l++)
      for (int j = 0; j < PPC; j++) begin
        t_len[l][j] = '0;
        t_pos[l][j] = '0;
      end
    for (int j = 0; j < PPC; j++) begin
      t_len[0][j] = cand_len[j];
      t_pos[0][j] = POS_W'(j);
    end
    for (int l = 0; l < LVLS; l++)
      for (int j = 0; j < (PPC >> (l + 1)); j++) begin
        if (t_len[l][2*j+1] > t_len[l][2*j]) begin
          t_len[l+1][j] = t_len[l][2*j+1];
          t_pos[l+1][j] = t_pos[l][2*j+1];
        end else begin
          t_len[l+1][j] = t_len[l][2*j];
          t_pos[l+1][j] = t_pos[l][2*j];
        end
      end
    cyc_best_len = t_len[LVLS][0];
    cyc_best_idx = base + IDX_W'(t_pos[LVLS][0]);
  end

  always_ff @(posedge clock) begin
    if (wr_fire) win[wr_ptr] <= writeData;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr            <= '0;
      fill              <= '0;
      pat_len           <= '0;
      cyc               <= '0;
      scan_done         <= 1'b0;
      acc_len           <= '0;
      acc_idx           <= '0;
      matchResultIndex  <= '0;
      matchResultLength <= '0;
    end else begin
      if (writeDataReady && historyClear) begin
        fill <= '0;
      end else if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != FILL_W'(HISTORY_DEPTH)) fill <= fill + 1'b1;
      end
      unique case (state)
        IDLE: if (pat_fire) begin
          pat               <= patternData;
          pat_len           <= patternDataLength;
          cyc               <= '0;
          scan_done         <= 1'b0;
          acc_len           <= '0;
          acc_idx           <= '0;
          matchResultIndex  <= '0;
          matchResultLength <= '0;
        end
        SEARCH: if (!scan_done) begin
          if (cyc_best_len > acc_len) begin
            acc_len <= cyc_best_len;
            acc_idx <= cyc_best_idx;
          end
          if (cyc == CYC_W'(SCAN_CYCLES - 1)) scan_done <= 1'b1;
          else                                cyc       <= cyc + 1'b1;
        end else begin
          matchResultIndex  <= acc_idx;
          matchResultLength <= acc_len;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lz77_windowed_pattern_search.sv
// Directed bench for lz77_windowed_pattern_search at default parameters.
module tb_lz77_windowed_pattern_search;

  logic        clock, reset, historyClear;
  logic        writeDataReady, writeDataValid;
  logic [7:0]  writeData;
  logic        patternDataReady, patternDataValid;
  logic [7:0]  patternData [7];
  logic [2:0]  patternDataLength;
  logic        matchResultReady, matchResultValid;
  logic [11:0] matchResultIndex;
  logic [2:0]  matchResultLength;

  int n_cmp = 0;
  int n_fail = 0;

  lz77_windowed_pattern_search dut (
    .clock(clock), .reset(reset), .historyClear(historyClear),
    .writeDataReady(writeDataReady), .writeDataValid(writeDataValid), .writeData(writeData),
    .patternDataReady(patternDataReady), .patternDataValid(patternDataValid),
    .patternData(patternData), .patternDataLength(patternDataLength),
    .matchResultReady(matchResultReady), .matchResultValid(matchResultValid),
    .matchResultIndex(matchResultIndex), .matchResultLength(matchResultLength)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    writeDataValid = 1'b1;
    writeData      = b;
    step();
    writeDataValid = 1'b0;
  endtask

  task automatic run_search(input logic [6:0][7:0] p, input int len, input bit with_wr,
                            input logic [7:0] wb, output logic [11:0] ri,
                            output logic [2:0] rl, output int lat);
    for (int k = 0; k < 7; k++) patternData[k] = p[k];
    patternDataLength = 3'(len);
    patternDataValid  = 1'b1;
    writeDataValid    = with_wr;
    writeData         = wb;
    step();
    patternDataValid  = 1'b0;
    writeDataValid    = 1'b0;
    lat = 0;
    while (matchResultValid !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
    ri = matchResultIndex;
    rl = matchResultLength;
  endtask

  task automatic accept();
    matchResultReady = 1'b1;
    step();
    matchResultReady = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
    n_cmp++; if (writeDataReady !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", writeDataReady); end
    n_cmp++; if (patternDataReady !== 1'b1) begin n_fail++; $display("FAIL reset_pat_ready: got %b want 1", patternDataReady); end
    n_cmp++; if (matchResultValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", matchResultValid); end
    n_cmp++; if (matchResultIndex !== 12'h000) begin n_fail++; $display("FAIL reset_index: got %h want 000", matchResultIndex); end
    n_cmp++; if (matchResultLength !== 3'd0) begin n_fail++; $display("FAIL reset_length: got %0d want 0", matchResultLength); end
  endtask

  task automatic test_reset_mid_search();
    logic [6:0][7:0] p;
    logic [11:0] ri; logic [2:0] rl; int lat; bit seen;
    put_byte(8'h41);
    for (int k = 0; k < 7; k++) patternData[k] = 8'h41;
    patternDataLength = 3'd1; patternDataValid = 1'b1; step(); patternDataValid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1; step(); reset = 1'b0;
    n_cmp++; if (writeDataReady !== 1'b1) begin n_fail++; $display("FAIL midrst_wr_ready: got %b want 1", writeDataReady); end
    n_cmp++; if (patternDataReady !== 1'b1) begin n_fail++; $display("FAIL midrst_pat_ready: got %b want 1", patternDataReady); end
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (matchResultValid !== 1'b0) seen = 1'b1;
      step();
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_valid: got %b want 0", seen); end
    p = '0; p[0] = 8'h41;
    run_search(p, 1, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (rl !== 3'd0) begin n_fail++; $display("FAIL midrst_fill0_len: got %0d want 0", rl); end
    n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL midrst_latency: got %0d want 65", lat); end
    accept();
  endtask

  task automatic test_full_window();
    logic [6:0][7:0] p;
    logic [11:0] ri; logic [2:0] rl; int lat;
    reset = 1'b1; step(); reset = 1'b0;
    writeDataValid = 1'b1;
    for (int i = 0; i < 4096; i++) begin writeData = 8'(i); step(); end
    writeDataValid = 1'b0;
    p = '0; p[0] = 8'h45; p[1] = 8'h46;
    run_search(p, 2, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL full_latency: got %0d want 65", lat); end
    n_cmp++; if (ri !== 12'h045) begin n_fail++; $display("FAIL full_index: got %h want 045", ri); end
    n_cmp++; if (rl !== 3'd2) begin n_fail++; $display("FAIL full_length: got %0d want 2", rl); end
    accept();
  endtask

  task automatic test_wrap();
    logic [6:0][7:0] p;
    logic [11:0] ri; logic [2:0] rl; int lat;
    logic [7:0] b;
    reset = 1'b1; step(); reset = 1'b0;
    writeDataValid = 1'b1;
    for (int i = 0; i < 4100; i++) begin
      case (i)
        0: b = 8'hAA; 1: b = 8'hBB; 2: b = 8'hCC; 3: b = 8'hDD;
        4: b = 8'hBB; 5: b = 8'hCC; 4099: b = 8'hAA;
        default: b = (i >= 4096) ? 8'h22 : 8'h11;
      endcase
      writeData = b;
      step();
    end
    writeDataValid = 1'b0;
    // Newest symbol AA sits at 3; BB CC at 4,5 are the oldest and must not be chained.
    p = '0; p[0] = 8'hAA; p[1] = 8'hBB; p[2] = 8'hCC;
    run_search(p, 3, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (ri !== 12'h003) begin n_fail++; $display("FAIL wrap_index: got %h want 003", ri); end
    n_cmp++; if (rl !== 3'd1) begin n_fail++; $display("FAIL wrap_length: got %0d want 1", rl); end
    accept();
    p = '0; p[0] = 8'hBB; p[1] = 8'hCC;
    run_search(p, 2, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (ri !== 12'h004) begin n_fail++; $display("FAIL wrap_oldest_index: got %h want 004", ri); end
    n_cmp++; if (rl !== 3'd2) begin n_fail++; $display("FAIL wrap_oldest_length: got %0d want 2", rl); end
    accept();
  endtask

  task automatic test_partial();
    logic [6:0][7:0] p;
    logic [11:0] ri; logic [2:0] rl; int lat;
    logic [7:0] s1 [7];
    logic [7:0] s2 [6];
    s1 = '{8'h41, 8'h42, 8'h58, 8'h41, 8'h42, 8'h43, 8'h44};
    s2 = '{8'h51, 8'h41, 8'h42, 8'h51, 8'h41, 8'h42};
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 7; i++) put_byte(s1[i]);
    p = '0; p[0] = 8'h41; p[1] = 8'h42; p[2] = 8'h43; p[3] = 8'h44; p[4] = 8'h45;
    run_search(p, 5, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (ri !== 12'h003) begin n_fail++; $display("FAIL partial_index: got %h want 003", ri); end
    n_cmp++; if (rl !== 3'd4) begin n_fail++; $display("FAIL partial_length: got %0d want 4", rl); end
    accept();
    // Clear keeps wr_ptr at 7; stale "AB" at 0 and 3 must be invisible.
    historyClear = 1'b1; step(); historyClear = 1'b0;
    for (int i = 0; i < 6; i++) put_byte(s2[i]);
    p = '0; p[0] = 8'h41; p[1] = 8'h42;
    run_search(p, 2, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (ri !== 12'h008) begin n_fail++; $display("FAIL tie_index: got %h want 008", ri); end
    n_cmp++; if (rl !== 3'd2) begin n_fail++; $display("FAIL tie_length: got %0d want 2", rl); end
    accept();
  endtask

  task automatic test_backpressure();
    logic [6:0][7:0] p;
    logic [11:0] ri; logic [2:0] rl; int lat;
    p = '0; p[0] = 8'h51; p[1] = 8'h41; p[2] = 8'h42;
    run_search(p, 3, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (ri !== 12'h007) begin n_fail++; $display("FAIL bp_index: got %h want 007", ri); end
    n_cmp++; if (rl !== 3'd3) begin n_fail++; $display("FAIL bp_length: got %0d want 3", rl); end
    writeDataValid = 1'b1; writeData = 8'h41;
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++;
      if (matchResultValid !== 1'b1 || matchResultIndex !== 12'h007 || matchResultLength !== 3'd3
          || writeDataReady !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v=%b i=%h l=%0d wr=%b want v=1 i=007 l=3 wr=0",
                 i, matchResultValid, matchResultIndex, matchResultLength, writeDataReady);
      end
    end
    writeDataValid = 1'b0;
    accept();
    n_cmp++; if (matchResultValid !== 1'b0 || writeDataReady !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b wr=%b want v=0 wr=1", matchResultValid, writeDataReady); end
    // A landed write of 41 after "...B" would make "BA" length 2.
    p = '0; p[0] = 8'h42; p[1] = 8'h41;
    run_search(p, 2, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (ri !== 12'h009) begin n_fail++; $display("FAIL bp_blocked_index: got %h want 009", ri); end
    n_cmp++; if (rl !== 3'd1) begin n_fail++; $display("FAIL bp_blocked_length: got %0d want 1", rl); end
    accept();
  endtask

  task automatic test_clear();
    logic [6:0][7:0] p;
    logic [11:0] ri; logic [2:0] rl; int lat;
    historyClear = 1'b1; writeDataValid = 1'b1; writeData = 8'h5A;
    step();
    historyClear = 1'b0; writeDataValid = 1'b0;
    p = '0; p[0] = 8'h5A;
    run_search(p, 1, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (rl !== 3'd0) begin n_fail++; $display("FAIL clear_length: got %0d want 0", rl); end
    n_cmp++; if (ri !== 12'h000) begin n_fail++; $display("FAIL clear_index: got %h want 000", ri); end
    n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL clear_latency: got %0d want 65", lat); end
    accept();
    put_byte(8'h59);
    p = '0; p[0] = 8'h59;
    run_search(p, 1, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (ri !== 12'h00D) begin n_fail++; $display("FAIL clear_wrptr_index: got %h want 00d", ri); end
    n_cmp++; if (rl !== 3'd1) begin n_fail++; $display("FAIL clear_wrptr_length: got %0d want 1", rl); end
    accept();
    run_search(p, 0, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (lat !== 0) begin n_fail++; $display("FAIL len0_latency: got %0d want 0", lat); end
    n_cmp++; if (rl !== 3'd0 || ri !== 12'h000) begin n_fail++; $display("FAIL len0_result: got i=%h l=%0d want i=000 l=0", ri, rl); end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [6:0][7:0] p;
    logic [11:0] ri; logic [2:0] rl; int lat;
    p = '0; p[0] = 8'h57;
    run_search(p, 1, 1'b1, 8'h57, ri, rl, lat);
    n_cmp++; if (ri !== 12'h00E) begin n_fail++; $display("FAIL samecycle_index: got %h want 00e", ri); end
    n_cmp++; if (rl !== 3'd1) begin n_fail++; $display("FAIL samecycle_length: got %0d want 1", rl); end
    n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL samecycle_latency: got %0d want 65", lat); end
    accept();
    p = '0; p[0] = 8'h59; p[1] = 8'h57;
    run_search(p, 2, 1'b0, 8'h00, ri, rl, lat);
    n_cmp++; if (ri !== 12'h00D) begin n_fail++; $display("FAIL b2b_index: got %h want 00d", ri); end
    n_cmp++; if (rl !== 3'd2) begin n_fail++; $display("FAIL b2b_length: got %0d want 2", rl); end
    accept();
  endtask

  initial begin
    reset = 1'b1; historyClear = 1'b0;
    writeDataValid = 1'b0; writeData = '0;
    patternDataValid = 1'b0; patternDataLength = '0;
    for (int k = 0; k < 7; k++) patternData[k] = '0;
    matchResultReady = 1'b0;
    test_reset();
    test_reset_mid_search();
    test_full_window();
    test_wrap();
    test_partial();
    test_backpressure();
    test_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
